rv_multicycle_ctrl: RTL and testbench

Multi-cycle main control unit that sits directly upstream of data_path. It accepts one 32-bit RV32I instruction word per handshake and steps it through FETCH/DECODE/EXEC/MEM/WB. In each state it drives the data_path control bundle: reg_write, alu_src, mem_write, alu_ctrl, mem_to_reg, branch and func3. It supports R-type, I-ALU, LW/SW and conditional branches, and flags illegal opcodes.

---
 rtl/rv_multicycle_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 tb/tb_rv_multicycle_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// rv_multicycle_ctrl
//
// Multi-cycle main control unit for an RV32I data path. One instruction word is
// accepted per instr_valid/instr_ready handshake and then stepped through
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB). The control bundle is decoded from
// the registered state and the latched instruction word.
//
// Supported: R-type ALU, I-type ALU, LW, SW, conditional branches.
// Unsupported opcodes, and branches with func3 = 010/011, set the sticky
// `illegal` flag and park the controller in TRAP until reset.
//
// Parameters
//   XLEN         instruction word width (only 32 is meaningful)
//   MEM_TIMEOUT  MEM wait cycles before the sticky mem_err flag sets (4-bit counter)
//
// Ports
//   clk, reset       clock; synchronous active-high reset
//   instr            instruction word from fetch
//   instr_valid      instr is valid this cycle
//   instr_ready      controller can accept an instruction (FETCH)
//   mem_ready        data memory completed the current load/store
//   reg_write        register-file write enable
//   alu_src          0 = rs2, 1 = immediate
//   mem_write        data memory write enable
//   alu_ctrl         ALU operation select
//   mem_to_reg       writeback select (1 = memory data)
//   branch           branch-evaluate strobe
//   func3            latched instr[14:12]
//   pc_en            one-cycle pulse on instruction retire
//   illegal          sticky unsupported-opcode flag
//   mem_err          sticky MEM timeout flag
//   retired_cnt      retired instruction count
//
// Build option
//   RETIRE_COUNTER_EN  when defined, retired_cnt is a 32-bit wrapping counter of
//                      pc_en pulses; otherwise it is tied to zero.
// -----------------------------------------------------------------------------
module rv_multicycle_ctrl #(
    parameter int XLEN        = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] instr,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic            mem_ready,
    output logic            reg_write,
    output logic            alu_src,
    output logic            mem_write,
    output logic [3:0]      alu_ctrl,
    output logic            mem_to_reg,
    output logic            branch,
    output logic [2:0]      func3,
    output logic            pc_en,
    output logic            illegal,
    output logic            mem_err,
    output logic [31:0]     retired_cnt
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    // Counter value seen in the last tolerated wait cycle; the next edge times out.
    localparam logic [3:0] WAIT_LAST_C = 4'(MEM_TIMEOUT - 1);

    // ALU operation for a latched instruction word. Loads/stores use ADD for the
    // address; branches compare with SUB (eq/ne), SLT (lt/ge) or SLTU (ltu/geu).
    function automatic logic [3:0] alu_decode(input logic [6:0] op,
                                              input logic [2:0] f3,
                                              input logic       b30);
        logic [3:0] res;
        res = ALU_ADD;
        case (op)
            OP_R, OP_I: begin
                case (f3)
                    3'b000:  res = (b30 && (op == OP_R)) ? ALU_SUB : ALU_ADD;
                    3'b001:  res = ALU_SLL;
                    3'b010:  res = ALU_SLT;
                    3'b011:  res = ALU_SLTU;
                    3'b100:  res = ALU_XOR;
                    3'b101:  res = b30 ? ALU_SRA : ALU_SRL;
                    3'b110:  res = ALU_OR;
                    3'b111:  res = ALU_AND;
                    default: res = ALU_ADD;
                endcase
            end
            OP_BR: begin
                case (f3)
                    3'b000, 3'b001: res = ALU_SUB;
                    3'b100, 3'b101: res = ALU_SLT;
                    3'b110, 3'b111: res = ALU_SLTU;
                    default:        res = ALU_ADD;
                endcase
            end
            default: res = ALU_ADD;
        endcase
        return res;
    endfunction

    state_t          state_r;
    state_t          state_next_s;
    logic [XLEN-1:0] ir_r;
    logic [3:0]      wait_cnt_r;
    logic            illegal_r;
    logic            mem_err_r;
    logic            illegal_set_s;
    logic            mem_err_set_s;

    logic            is_r_s;
    logic            is_i_s;
    logic            is_lw_s;
    logic            is_sw_s;
    logic            is_br_s;
    logic            legal_s;
    logic [3:0]      alu_op_s;

    logic            instr_ready_s;
    logic            reg_write_s;
    logic            alu_src_s;
    logic            mem_write_s;
    logic [3:0]      alu_ctrl_s;
    logic            mem_to_reg_s;
    logic            branch_s;
    logic [2:0]      func3_s;
    logic            pc_en_s;

    // Only opcode, func3 and bit 30 steer control; the rest of the word is latched
    // so the instruction register holds the full handshake value.
    logic            ir_unused_s;
    assign ir_unused_s = ^{ir_r[31], ir_r[29:15], ir_r[11:7]};

    // Instruction class of the latched word.
    always_comb begin
        is_r_s   = (ir_r[6:0] == OP_R);
        is_i_s   = (ir_r[6:0] == OP_I);
        is_lw_s  = (ir_r[6:0] == OP_LW);
        is_sw_s  = (ir_r[6:0] == OP_SW);
        // Branch func3 010/011 has no RV32I meaning and is rejected at DECODE.
        is_br_s  = (ir_r[6:0] == OP_BR) && (ir_r[14:13] != 2'b01);
        legal_s  = is_r_s | is_i_s | is_lw_s | is_sw_s | is_br_s;
        alu_op_s = alu_decode(ir_r[6:0], ir_r[14:12], ir_r[30]);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Instruction register: captured only on the FETCH handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            ir_r <= '0;
        end else if ((state_r == ST_FETCH) && instr_valid) begin
            ir_r <= instr;
        end else begin
            ir_r <= ir_r;
        end
    end

    // MEM wait counter: counts unacknowledged MEM cycles, idle at zero elsewhere.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_r <= 4'd0;
        end else if ((state_r == ST_MEM) && !mem_ready) begin
            wait_cnt_r <= wait_cnt_r + 4'd1;
        end else begin
            wait_cnt_r <= 4'd0;
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_r <= 1'b0;
            mem_err_r <= 1'b0;
        end else begin
            illegal_r <= illegal_r | illegal_set_s;
            mem_err_r <= mem_err_r | mem_err_set_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s  = state_r;
        illegal_set_s = 1'b0;
        mem_err_set_s = 1'b0;
        case (state_r)
            ST_FETCH: begin
                if (instr_valid) begin
                    state_next_s = ST_DECODE;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (legal_s) begin
                    state_next_s = ST_EXEC;
                end else begin
                    state_next_s  = ST_TRAP;
                    illegal_set_s = 1'b1;
                end
            end
            ST_EXEC: begin
                if (is_r_s || is_i_s) begin
                    state_next_s = ST_WB;
                end else if (is_lw_s || is_sw_s) begin
                    state_next_s = ST_MEM;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_MEM: begin
                // An acknowledge in the last tolerated cycle still completes.
                if (mem_ready) begin
                    state_next_s = is_lw_s ? ST_WB : ST_FETCH;
                end else if (wait_cnt_r == WAIT_LAST_C) begin
                    state_next_s  = ST_FETCH;
                    mem_err_set_s = 1'b1;
                end else begin
                    state_next_s = ST_MEM;
                end
            end
            ST_WB:   state_next_s = ST_FETCH;
            ST_TRAP: state_next_s = ST_TRAP;
            default: state_next_s = ST_FETCH;
        endcase
    end

    // Control bundle decoded from state and latched instruction.
    always_comb begin
        instr_ready_s = 1'b0;
        reg_write_s   = 1'b0;
        alu_src_s     = 1'b0;
        mem_write_s   = 1'b0;
        alu_ctrl_s    = ALU_ADD;
        mem_to_reg_s  = 1'b0;
        branch_s      = 1'b0;
        pc_en_s       = 1'b0;
        func3_s       = ir_r[14:12];
        case (state_r)
            ST_FETCH:  instr_ready_s = 1'b1;
            ST_DECODE: instr_ready_s = 1'b0;
            ST_EXEC: begin
                alu_src_s  = is_i_s | is_lw_s | is_sw_s;
                alu_ctrl_s = alu_op_s;
                branch_s   = is_br_s;
                pc_en_s    = is_br_s;
            end
            ST_MEM: begin
                alu_src_s    = 1'b1;
                alu_ctrl_s   = alu_op_s;
                mem_write_s  = is_sw_s;
                mem_to_reg_s = is_lw_s;
                // A store retires in the very cycle memory acknowledges it.
                pc_en_s      = is_sw_s & mem_ready;
            end
            ST_WB: begin
                reg_write_s  = 1'b1;
                pc_en_s      = 1'b1;
                mem_to_reg_s = is_lw_s;
                alu_src_s    = is_i_s | is_lw_s;
                alu_ctrl_s   = alu_op_s;
            end
            ST_TRAP: func3_s = 3'd0;
            default: func3_s = 3'd0;
        endcase
    end

    assign instr_ready = instr_ready_s;
    assign reg_write   = reg_write_s;
    assign alu_src     = alu_src_s;
    assign mem_write   = mem_write_s;
    assign alu_ctrl    = alu_ctrl_s;
    assign mem_to_reg  = mem_to_reg_s;
    assign branch      = branch_s;
    assign func3       = func3_s;
    assign pc_en       = pc_en_s;
    assign illegal     = illegal_r;
    assign mem_err     = mem_err_r;

`ifdef RETIRE_COUNTER_EN
    logic [31:0] retired_r;

    // Retired-instruction counter; wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            retired_r <= 32'd0;
        end else if (pc_en_s) begin
            retired_r <= retired_r + 32'd1;
        end else begin
            retired_r <= retired_r;
        end
    end

    assign retired_cnt = retired_r;
`else
    assign retired_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for rv_multicycle_ctrl.
// A reference model turns (instruction, memory wait cycles) into the expected
// cycle-by-cycle control bundle; a table of hand-derived vectors, a few
// hand-written reset/trap sequences and a randomized run are all compared
// against that trace. Inputs change and outputs are sampled around the falling
// clock edge.
// -----------------------------------------------------------------------------
module tb_rv_multicycle_ctrl;

    localparam int MEM_TIMEOUT = 15;
    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BR = 4, K_ILL = 5;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        mem_ready;
    logic        reg_write;
    logic        alu_src;
    logic        mem_write;
    logic [3:0]  alu_ctrl;
    logic        mem_to_reg;
    logic        branch;
    logic [2:0]  func3;
    logic        pc_en;
    logic        illegal;
    logic        mem_err;
    logic [31:0] retired_cnt;

    rv_multicycle_ctrl #(.XLEN(32), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .mem_ready(mem_ready), .reg_write(reg_write),
        .alu_src(alu_src), .mem_write(mem_write), .alu_ctrl(alu_ctrl),
        .mem_to_reg(mem_to_reg), .branch(branch), .func3(func3), .pc_en(pc_en),
        .illegal(illegal), .mem_err(mem_err), .retired_cnt(retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One expected clock cycle: stimulus to drive plus outputs to expect.
    typedef struct {
        logic        vld;
        logic [31:0] ins;
        logic        mr;
        logic        rdy, rw, asrc, mw;
        logic [3:0]  actl;
        logic        m2r, br;
        logic [2:0]  f3;
        logic        pc, ill, merr;
        logic [31:0] ret;
    } cyc_t;

    typedef struct {
        logic [31:0] ins;
        int          waits;
        logic [3:0]  alu;
        logic        asrc;
        int          cpi;     // cycles handshake -> pc_en, 0 = never retires
    } vec_t;

    int          n_cmp = 0;
    int          n_err = 0;
    cyc_t        trace_q[$];
    int          hs_idx;
    logic        m_ill, m_merr;
    logic [2:0]  m_f3;
    logic [31:0] m_ret;
    logic [3:0]  obs_alu;
    logic        obs_asrc;
    int          obs_cpi;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] ret_exp();
`ifdef RETIRE_COUNTER_EN
        return m_ret;
`else
        return 32'd0;
`endif
    endfunction

    task automatic model_reset();
        m_ill  = 1'b0;
        m_merr = 1'b0;
        m_f3   = 3'd0;
        m_ret  = 32'd0;
    endtask

    // A cycle with every control low; don't-care inputs are randomized.
    function automatic cyc_t blank_cyc();
        cyc_t c;
        c.vld  = 1'($urandom);
        c.ins  = $urandom;
        c.mr   = 1'($urandom);
        c.rdy  = 1'b0; c.rw = 1'b0; c.asrc = 1'b0; c.mw = 1'b0;
        c.actl = 4'd0; c.m2r = 1'b0; c.br = 1'b0; c.pc = 1'b0;
        c.f3   = m_f3;
        c.ill  = m_ill;
        c.merr = m_merr;
        c.ret  = ret_exp();
        return c;
    endfunction

    function automatic int classify(input logic [31:0] ins);
        case (ins[6:0])
            7'b0110011: return K_R;
            7'b0010011: return K_I;
            7'b0000011: return K_LW;
            7'b0100011: return K_SW;
            7'b1100011: return (ins[14:12] == 3'd2 || ins[14:12] == 3'd3) ? K_ILL : K_BR;
            default:    return K_ILL;
        endcase
    endfunction

    function automatic logic [3:0] ref_alu(input int k, input logic [31:0] ins);
        logic [3:0] by_f3 [0:7];
        logic [2:0] f;
        logic [3:0] r;
        // func3-indexed: ADD SLL SLT SLTU XOR SRL OR AND
        by_f3 = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
        f = ins[14:12];
        r = 4'd0;
        if (k == K_BR) begin
            if (f < 3'd4)      r = 4'd1;
            else if (f < 3'd6) r = 4'd8;
            else               r = 4'd9;
        end else if (k == K_R || k == K_I) begin
            r = by_f3[f];
            if (ins[30] && f == 3'd5) r = 4'd7;
            if (ins[30] && f == 3'd0 && k == K_R) r = 4'd1;
        end
        return r;
    endfunction

    // Expected trace for one instruction: idle FETCH cycles, the handshake, and
    // every following cycle up to (not including) the next FETCH.
    task automatic build_trace(input logic [31:0] ins, input int waits, input int idle);
        cyc_t       c;
        int         k;
        int         n;
        logic [3:0] a;
        k = classify(ins);
        a = ref_alu(k, ins);
        trace_q.delete();
        for (int i = 0; i < idle; i++) begin
            c = blank_cyc(); c.rdy = 1'b1; c.vld = 1'b0; trace_q.push_back(c);
        end
        hs_idx = idle;
        c = blank_cyc(); c.rdy = 1'b1; c.vld = 1'b1; c.ins = ins; trace_q.push_back(c);
        m_f3 = ins[14:12];
        trace_q.push_back(blank_cyc());                 // DECODE
        if (k == K_ILL) begin
            m_ill = 1'b1;
            for (int i = 0; i < 4; i++) begin
                c = blank_cyc(); c.f3 = 3'd0; trace_q.push_back(c);
            end
            return;
        end
        c = blank_cyc();                                // EXEC
        c.asrc = (k == K_I || k == K_LW || k == K_SW);
        c.actl = a;
        c.br   = (k == K_BR);
        c.pc   = (k == K_BR);
        trace_q.push_back(c);
        if (k == K_BR) begin m_ret++; return; end
        if (k == K_LW || k == K_SW) begin
            n = (waits >= MEM_TIMEOUT) ? MEM_TIMEOUT : waits + 1;
            for (int i = 0; i < n; i++) begin
                c = blank_cyc();
                c.asrc = 1'b1; c.actl = a;
                c.mw   = (k == K_SW); c.m2r = (k == K_LW);
                c.mr   = (waits < MEM_TIMEOUT) && (i == n - 1);
                c.pc   = c.mr && (k == K_SW);
                trace_q.push_back(c);
            end
            if (waits >= MEM_TIMEOUT) begin m_merr = 1'b1; return; end
            if (k == K_SW) begin m_ret++; return; end
        end
        c = blank_cyc();                                // WB
        c.rw = 1'b1; c.pc = 1'b1; c.m2r = (k == K_LW);
        c.asrc = (k == K_I || k == K_LW); c.actl = a;
        trace_q.push_back(c);
        m_ret++;
    endtask

    task automatic compare_cycle(input cyc_t c);
        check("instr_ready", {31'd0, instr_ready}, {31'd0, c.rdy});
        check("reg_write",   {31'd0, reg_write},   {31'd0, c.rw});
        check("alu_src",     {31'd0, alu_src},     {31'd0, c.asrc});
        check("mem_write",   {31'd0, mem_write},   {31'd0, c.mw});
        check("alu_ctrl",    {28'd0, alu_ctrl},    {28'd0, c.actl});
        check("mem_to_reg",  {31'd0, mem_to_reg},  {31'd0, c.m2r});
        check("branch",      {31'd0, branch},      {31'd0, c.br});
        check("func3",       {29'd0, func3},       {29'd0, c.f3});
        check("pc_en",       {31'd0, pc_en},       {31'd0, c.pc});
        check("illegal",     {31'd0, illegal},     {31'd0, c.ill});
        check("mem_err",     {31'd0, mem_err},     {31'd0, c.merr});
        check("retired_cnt", retired_cnt,          c.ret);
    endtask

    // Drive the trace; reset is raised in cycle reset_at (-1 = never) and the
    // trace stops there.
    task automatic apply_trace(input int reset_at);
        cyc_t c;
        obs_cpi  = 0;
        obs_alu  = 4'd0;
        obs_asrc = 1'b0;
        for (int i = 0; i < trace_q.size(); i++) begin
            c = trace_q[i];
            @(negedge clk);
            instr_valid = c.vld;
            instr       = c.ins;
            mem_ready   = c.mr;
            reset       = (i == reset_at);
            #1;
            compare_cycle(c);
            if (i == hs_idx + 2) begin
                obs_alu  = alu_ctrl;
                obs_asrc = alu_src;
            end
            if (pc_en === 1'b1 && obs_cpi == 0) obs_cpi = i - hs_idx;
            if (i == reset_at) break;
        end
    endtask

    // Release a reset raised in the previous cycle and check the reset state.
    task automatic release_check();
        cyc_t c;
        @(negedge clk);
        reset       = 1'b0;
        instr_valid = 1'b0;
        mem_ready   = 1'($urandom);
        model_reset();
        #1;
        c = blank_cyc(); c.rdy = 1'b1;
        compare_cycle(c);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b1;
        instr_valid = 1'b1;          // reset must win over a handshake
        instr       = $urandom;
        mem_ready   = 1'($urandom);
        release_check();
    endtask

    vec_t tbl [22];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl = '{
            '{32'h00A00293,  0, 4'd0, 1'b1,  3},   // addi
            '{32'h005303B3,  0, 4'd0, 1'b0,  3},   // add
            '{32'h405303B3,  0, 4'd1, 1'b0,  3},   // sub
            '{32'h00002283,  3, 4'd0, 1'b1,  7},   // lw, 3 waits
            '{32'h00502023,  2, 4'd0, 1'b1,  5},   // sw, 2 waits
            '{32'h00000063,  0, 4'd1, 1'b0,  2},   // beq
            '{32'h4053D3B3,  0, 4'd7, 1'b0,  3},   // sra
            '{32'h4032D313,  0, 4'd7, 1'b1,  3},   // srai
            '{32'hC0000293,  0, 4'd0, 1'b1,  3},   // addi, bit30 set -> still ADD
            '{32'h00006063,  0, 4'd9, 1'b0,  2},   // bltu
            '{32'h00004063,  0, 4'd8, 1'b0,  2},   // blt
            '{32'h0002A293,  0, 4'd8, 1'b1,  3},   // slti
            '{32'h0002B2B3,  0, 4'd9, 1'b0,  3},   // sltu
            '{32'h0002F2B3,  0, 4'd2, 1'b0,  3},   // and
            '{32'h0002E2B3,  0, 4'd3, 1'b0,  3},   // or
            '{32'h0002C2B3,  0, 4'd4, 1'b0,  3},   // xor
            '{32'h000292B3,  0, 4'd5, 1'b0,  3},   // sll
            '{32'h0002D2B3,  0, 4'd6, 1'b0,  3},   // srl
            '{32'h00002283, 14, 4'd0, 1'b1, 18},   // lw, ack in last tolerated cycle
            '{32'h00502023,  0, 4'd0, 1'b1,  3},   // sw, no wait
            '{32'h00502023, 15, 4'd0, 1'b1,  0},   // sw timeout: never retires
            '{32'h00A00293,  0, 4'd0, 1'b1,  3}    // addi after mem_err
        };

        reset       = 1'b1;
        instr       = 32'd0;
        instr_valid = 1'b0;
        mem_ready   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        release_check();

        // Table-driven vectors.
        for (int i = 0; i < 22; i++) begin
            build_trace(tbl[i].ins, tbl[i].waits, i % 2);
            apply_trace(-1);
            check("tbl_alu_exec",  {28'd0, obs_alu},  {28'd0, tbl[i].alu});
            check("tbl_alu_src",   {31'd0, obs_asrc}, {31'd0, tbl[i].asrc});
            check("tbl_cpi",       obs_cpi,           tbl[i].cpi);
        end

        // Reset in the second MEM cycle of a store that memory never acknowledges.
        do_reset();
        build_trace(32'h00502023, 20, 0);
        apply_trace(hs_idx + 4);
        release_check();

        // Illegal opcode and illegal branch func3: trap until reset.
        build_trace(32'hFFFFFFFF, 0, 1);
        apply_trace(-1);
        do_reset();
        build_trace(32'h00002063, 0, 0);
        apply_trace(-1);
        do_reset();

        // Randomized instructions against the reference model.
        for (int it = 0; it < 150; it++) begin
            logic [31:0] ins;
            int          sel;
            int          w;
            ins = $urandom;
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1:    ins[6:0] = 7'b0110011;
                2, 3:    ins[6:0] = 7'b0010011;
                4:       ins[6:0] = 7'b0000011;
                5:       ins[6:0] = 7'b0100011;
                6, 7:    ins[6:0] = 7'b1100011;
                default: ins[6:0] = ins[6:0];
            endcase
            w = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 5);
            build_trace(ins, w, $urandom_range(0, 2));
            apply_trace(-1);
            if (classify(ins) == K_ILL) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
